// File: rtl/first_match_seq_checker_if.sv
// rtl/first_match_seq_checker_if.sv - monitored-signal and status bundle for first_match_seq_checker
interface first_match_seq_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             p;
  logic             q;
  logic             r;
  logic             s;
  logic             busy;
  logic             pass;
  logic             fail;
  logic             vacuous;
  logic             drop;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] vac_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output en, clr, p, q, r, s,
    input  busy, pass, fail, vacuous, drop,
    input  pass_cnt, fail_cnt, vac_cnt, drop_cnt
  );

  modport slave (
    input  en, clr, p, q, r, s,
    output busy, pass, fail, vacuous, drop,
    output pass_cnt, fail_cnt, vac_cnt, drop_cnt
  );
endinterface

// File: rtl/first_match_seq_checker.sv
// rtl/first_match_seq_checker.sv - checker for p ##1 first_match(q[*MIN_Q:MAX_Q] ##1 r) |=> s[*S_LEN]
module first_match_seq_checker #(
  parameter int MIN_Q = 1,
  parameter int MAX_Q = 3,
  parameter int S_LEN = 2,
  parameter int CNT_W = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  first_match_seq_checker_if.slave    bus
);

  localparam int QW = $clog2(MAX_Q + 1);
  localparam int SW = $clog2(S_LEN + 1);

  if (MIN_Q < 1)     begin : g_bad_min_q $error("MIN_Q must be >= 1"); end
  if (MAX_Q < MIN_Q) begin : g_bad_max_q $error("MAX_Q must be >= MIN_Q"); end
  if (S_LEN < 1)     begin : g_bad_s_len $error("S_LEN must be >= 1"); end
  if (CNT_W < 1)     begin : g_bad_cnt_w $error("CNT_W must be >= 1"); end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    Q_RUN = 2'd1,
    S_CHK = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [QW-1:0]    r_qcnt;
  logic [QW-1:0]    w_qcnt_nxt;
  logic [SW-1:0]    r_scnt;
  logic [SW-1:0]    w_scnt_nxt;

  logic             w_pass;
  logic             w_fail;
  logic             w_vac;
  logic             w_drop;
  logic             r_pass;
  logic             r_fail;
  logic             r_vac;
  logic             r_drop;

  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_vac_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_scnt_nxt  = r_scnt;
    w_pass      = 1'b0;
    w_fail      = 1'b0;
    w_vac       = 1'b0;
    w_drop      = 1'b0;
    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_qcnt_nxt  = '0;
      w_scnt_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.p) begin
            w_state_nxt = Q_RUN;
            w_qcnt_nxt  = '0;
          end
        end
        Q_RUN: begin
          w_drop = bus.p;
          // r closes the antecedent as soon as the minimum is met, even with q still high
          if (r_qcnt >= QW'(MIN_Q) && bus.r) begin
            w_state_nxt = S_CHK;
            w_scnt_nxt  = '0;
          end else if (bus.q && r_qcnt < QW'(MAX_Q)) begin
            w_qcnt_nxt = r_qcnt + 1'b1;
          end else begin
            w_vac       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        S_CHK: begin
          w_drop = bus.p;
          if (bus.s) begin
            if (r_scnt == SW'(S_LEN - 1)) begin
              w_pass      = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_scnt_nxt = r_scnt + 1'b1;
            end
          end else begin
            w_fail      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic ev);
    sat_inc = (ev && cnt != {CNT_W{1'b1}}) ? cnt + 1'b1 : cnt;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_qcnt  <= '0;
      r_scnt  <= '0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_vac   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
      r_scnt  <= w_scnt_nxt;
      r_pass  <= w_pass;
      r_fail  <= w_fail;
      r_vac   <= w_vac;
      r_drop  <= w_drop;
    end
  end

  // Counters advance on the deciding edge so they line up with their pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_vac_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (bus.clr) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_vac_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pass_cnt <= sat_inc(r_pass_cnt, w_pass);
      r_fail_cnt <= sat_inc(r_fail_cnt, w_fail);
      r_vac_cnt  <= sat_inc(r_vac_cnt,  w_vac);
      r_drop_cnt <= sat_inc(r_drop_cnt, w_drop);
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.pass     = r_pass;
  assign bus.fail     = r_fail;
  assign bus.vacuous  = r_vac;
  assign bus.drop     = r_drop;
  assign bus.pass_cnt = r_pass_cnt;
  assign bus.fail_cnt = r_fail_cnt;
  assign bus.vac_cnt  = r_vac_cnt;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_first_match_seq_checker.sv
// tb/tb_first_match_seq_checker.sv - directed bench for first_match_seq_checker
module tb_first_match_seq_checker;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  first_match_seq_checker_if #(.CNT_W(2)) bus ();

  first_match_seq_checker #(
    .MIN_Q(1), .MAX_Q(3), .S_LEN(2), .CNT_W(2)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedge, the posedge samples them, outputs are read at the next negedge
  task automatic cyc(input logic p, input logic q, input logic r, input logic s);
    bus.p = p;
    bus.q = q;
    bus.r = r;
    bus.s = s;
    @(posedge clk);
    @(negedge clk);
    bus.p = 1'b0;
    bus.q = 1'b0;
    bus.r = 1'b0;
    bus.s = 1'b0;
  endtask

  task automatic clear_counters();
    bus.clr = 1'b1;
    cyc(0, 0, 0, 0);
    bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.en  = 1'b1;
    bus.clr = 1'b0;
    bus.p = 1'b0; bus.q = 1'b0; bus.r = 1'b0; bus.s = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.pass !== 1'b0 || bus.fail !== 1'b0 || bus.vacuous !== 1'b0 || bus.drop !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses got busy=%b pass=%b fail=%b vac=%b drop=%b exp all 0",
               bus.busy, bus.pass, bus.fail, bus.vacuous, bus.drop);
    end
    total++;
    if (bus.pass_cnt !== 2'd0 || bus.fail_cnt !== 2'd0 || bus.vac_cnt !== 2'd0 || bus.drop_cnt !== 2'd0) begin
      bad++;
      $display("FAIL reset_counters got %0d %0d %0d %0d exp 0 0 0 0",
               bus.pass_cnt, bus.fail_cnt, bus.vac_cnt, bus.drop_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass();
    clear_counters();
    cyc(1, 0, 0, 0);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL pass_busy_e0 got=%b exp=1", bus.busy); end
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    total++;
    if (bus.busy !== 1'b1 || bus.pass !== 1'b0) begin
      bad++; $display("FAIL pass_mid got busy=%b pass=%b exp busy=1 pass=0", bus.busy, bus.pass);
    end
    cyc(0, 0, 0, 1);
    total++;
    if (bus.pass !== 1'b1 || bus.fail !== 1'b0) begin
      bad++; $display("FAIL pass_pulse got pass=%b fail=%b exp pass=1 fail=0", bus.pass, bus.fail);
    end
    total++;
    if (bus.pass_cnt !== 2'd1) begin bad++; $display("FAIL pass_cnt got=%0d exp=1", bus.pass_cnt); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL pass_busy_end got=%b exp=0", bus.busy); end
    cyc(0, 0, 0, 0);
    total++;
    if (bus.pass !== 1'b0) begin bad++; $display("FAIL pass_one_cycle got=%b exp=0", bus.pass); end
  endtask

  task automatic test_fail();
    clear_counters();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    total++;
    if (bus.fail !== 1'b1 || bus.pass !== 1'b0) begin
      bad++; $display("FAIL fail_pulse got fail=%b pass=%b exp fail=1 pass=0", bus.fail, bus.pass);
    end
    total++;
    if (bus.fail_cnt !== 2'd1) begin bad++; $display("FAIL fail_cnt got=%0d exp=1", bus.fail_cnt); end
  endtask

  task automatic test_min_rule();
    clear_counters();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    total++;
    if (bus.busy !== 1'b1 || bus.vacuous !== 1'b0) begin
      bad++; $display("FAIL min_early_r got busy=%b vac=%b exp busy=1 vac=0", bus.busy, bus.vacuous);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    total++;
    if (bus.pass !== 1'b0) begin bad++; $display("FAIL min_no_early_pass got=%b exp=0", bus.pass); end
    cyc(0, 0, 0, 1);
    total++;
    if (bus.pass !== 1'b1 || bus.pass_cnt !== 2'd1) begin
      bad++; $display("FAIL min_pass got pass=%b cnt=%0d exp pass=1 cnt=1", bus.pass, bus.pass_cnt);
    end
  endtask

  task automatic test_max_rule();
    clear_counters();
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0);
    total++;
    if (bus.vacuous !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL max_before got vac=%b busy=%b exp vac=0 busy=1", bus.vacuous, bus.busy);
    end
    cyc(0, 1, 0, 0);
    total++;
    if (bus.vacuous !== 1'b1 || bus.fail !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL max_vacuous got vac=%b fail=%b busy=%b exp vac=1 fail=0 busy=0",
                      bus.vacuous, bus.fail, bus.busy);
    end
    total++;
    if (bus.vac_cnt !== 2'd1 || bus.fail_cnt !== 2'd0) begin
      bad++; $display("FAIL max_counts got vac=%0d fail=%0d exp vac=1 fail=0", bus.vac_cnt, bus.fail_cnt);
    end
  endtask

  task automatic test_drop_and_reset();
    clear_counters();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    total++;
    if (bus.drop !== 1'b1 || bus.drop_cnt !== 2'd1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL drop_pulse got drop=%b cnt=%0d busy=%b exp 1 1 1", bus.drop, bus.drop_cnt, bus.busy);
    end
    cyc(0, 0, 1, 0);
    total++;
    if (bus.busy !== 1'b1 || bus.drop !== 1'b0) begin
      bad++; $display("FAIL drop_continue got busy=%b drop=%b exp busy=1 drop=0", bus.busy, bus.drop);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.drop_cnt !== 2'd0 || bus.pass !== 1'b0 || bus.fail !== 1'b0) begin
      bad++; $display("FAIL async_reset got busy=%b drop_cnt=%0d pass=%b fail=%b exp all 0",
                      bus.busy, bus.drop_cnt, bus.pass, bus.fail);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_disable();
    clear_counters();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    bus.en = 1'b0;
    cyc(1, 0, 0, 0);
    total++;
    if (bus.busy !== 1'b0 || bus.vacuous !== 1'b0 || bus.drop !== 1'b0) begin
      bad++; $display("FAIL disable_abort got busy=%b vac=%b drop=%b exp 0 0 0", bus.busy, bus.vacuous, bus.drop);
    end
    total++;
    if (bus.vac_cnt !== 2'd0 || bus.drop_cnt !== 2'd0) begin
      bad++; $display("FAIL disable_counts got vac=%0d drop=%0d exp 0 0", bus.vac_cnt, bus.drop_cnt);
    end
    bus.en = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_pass(input logic clr_last);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    bus.clr = clr_last;
    cyc(0, 0, 0, 1);
    bus.clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_counters();
    for (int i = 0; i < 5; i++) begin
      run_pass(1'b0);
      if (i == 2) begin
        total++;
        if (bus.pass_cnt !== 2'd3) begin bad++; $display("FAIL b2b_cnt3 got=%0d exp=3", bus.pass_cnt); end
      end
    end
    total++;
    if (bus.pass !== 1'b1 || bus.pass_cnt !== 2'd3) begin
      bad++; $display("FAIL b2b_saturate got pass=%b cnt=%0d exp pass=1 cnt=3", bus.pass, bus.pass_cnt);
    end
    run_pass(1'b1);
    total++;
    if (bus.pass !== 1'b1 || bus.pass_cnt !== 2'd0) begin
      bad++; $display("FAIL clr_priority got pass=%b cnt=%0d exp pass=1 cnt=0", bus.pass, bus.pass_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_pass();
    test_fail();
    test_min_rule();
    test_max_rule();
    test_drop_and_reset();
    test_disable();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/first_match_seq_checker.md
Name: first_match_seq_checker

Overview:
- Synthesizable RTL checker that implements the property `p ##1 first_match(q[*MIN_Q:MAX_Q] ##1 r) |=> s[*S_LEN]`.
- Intended for silicon/emulation builds, where the SVA equivalents are unavailable.
- Sequences one attempt at a time through an FSM and reports pass/fail/vacuous pulses.
- Keeps saturating event counters for status readout.

Parameters:
- MIN_Q, 1, minimum consecutive q cycles before r may end the antecedent (≥1)
- MAX_Q, 3, maximum consecutive q cycles (≥MIN_Q)
- S_LEN, 2, consecutive s cycles required after match (≥1)
- CNT_W, 8, width of each saturating event counter

Ports:
- clk  in  1  clock, all sampling on posedge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  checker enable; 0 holds IDLE, in-flight attempt aborted silently
- clr  in  1  synchronous clear of all counters
- p, q, r, s  in  1 each  monitored signals
- busy  out  1  attempt in progress (state != IDLE)
- pass  out  1  one-cycle pulse: consequent satisfied
- fail  out  1  one-cycle pulse: antecedent matched, consequent violated
- vacuous  out  1  one-cycle pulse: antecedent started by p but not matched
- drop  out  1  one-cycle pulse: p sampled while busy, attempt not started
- pass_cnt, fail_cnt, vac_cnt, drop_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, qcnt=0, scnt=0.
  - All pulses 0, all counters 0, busy=0.
- Output registration and latency:
  - All outputs registered.
  - A pulse is visible for exactly the one cycle after the posedge that decided it.
- States: IDLE, Q_RUN, S_CHK.
- IDLE:
  - p=1 and en=1 → Q_RUN, qcnt=0.
- Q_RUN (first sample is the edge after p), evaluated in this priority order:
  - (a) qcnt≥MIN_Q and r=1 → match → S_CHK, scnt=0. This is first-match semantics: r ends the sequence even if q=1 in the same cycle.
  - (b) else q=1 and qcnt<MAX_Q → qcnt+1, stay in Q_RUN.
  - (c) else → vacuous pulse, IDLE.
- S_CHK (first sample is the edge after the matching r):
  - s=1 and scnt==S_LEN-1 → pass pulse, IDLE.
  - s=1 otherwise → scnt+1.
  - s=0 → fail pulse, IDLE.
- Single attempt in flight:
  - p=1 sampled while state≠IDLE (including the deciding edge) → drop pulse.
  - The FSM is unaffected by the dropped p.
- Counter sizing and updates:
  - qcnt width is $clog2(MAX_Q+1).
  - scnt width is $clog2(S_LEN+1).
  - Each event counter increments on its pulse and saturates at 2^CNT_W-1.
- Counter clear:
  - clr=1 zeroes all counters on that edge.
  - clr has priority over a same-edge increment.
- en=0: forces IDLE next edge.
  - No pulses are generated and counters are held.
  - clr still works.
- Reset asserted mid-attempt aborts immediately with no pulse.
- Parameter legality is checked at elaboration with $error: MIN_Q≥1, MAX_Q≥MIN_Q, S_LEN≥1, CNT_W≥1.

Test Plan:
1. Defaults. p@e0; q@e1–e3; r@e4; s@e5–e6 → busy e1–e6; pass=1 after e6; pass_cnt=1; fail=0.
2. p@e0; q@e1; r@e2; s@e3; s=0@e4 → fail=1 after e4; fail_cnt=1.
3. Min rule. p@e0; q=r=1@e1 (qcnt=0, r ignored); r@e2; s@e3–e4 → match at e2, pass after e4.
4. Max rule. p@e0; q=1,r=0@e1–e4 → vacuous=1 after e4 (qcnt=3, no r); vac_cnt=1; no fail.
5. Drop and reset. p@e0, p again@e2 while in Q_RUN → drop=1 after e2, drop_cnt=1, attempt continues. Then rst_n=0 during S_CHK → busy=0, all counters 0 immediately.
6. Saturation. CNT_W=2; five back-to-back passing attempts → pass_cnt=3. clr@next edge together with a pass pulse → pass_cnt=0.
